// File: rtl/mem_req_master_if.sv
// mem_req_master_if
// Bundles the three handshakes of the request master:
//   cmd_*  : command stream into the master (valid/ready, write flag, address, write data)
//   mem_*  : single-cycle request to the memory and its ready/read-data return
//   rsp_*  : read response stream out of the master (valid/ready, data, address)
//   err    : one-cycle pulse when a request is abandoned on timeout
//   busy   : master has queued or in-flight work
// Modport master is the request master's view; slave is the environment's view
// (command source, memory and response consumer together).
interface mem_req_master_if #(
  parameter int MEMORY_WIDTH  = 8,
  parameter int ADDRESS_WIDTH = 4
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic                     cmd_wr;
  logic [ADDRESS_WIDTH-1:0] cmd_addr;
  logic [MEMORY_WIDTH-1:0]  cmd_wdata;

  logic                     mem_valid;
  logic                     mem_wr_rd_en;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [MEMORY_WIDTH-1:0]  mem_wdata;
  logic [MEMORY_WIDTH-1:0]  mem_rdata;
  logic                     mem_ready;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [MEMORY_WIDTH-1:0]  rsp_rdata;
  logic [ADDRESS_WIDTH-1:0] rsp_addr;

  logic                     err;
  logic                     busy;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
    output cmd_ready,
    output mem_valid, mem_wr_rd_en, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output rsp_valid, rsp_rdata, rsp_addr,
    input  rsp_ready,
    output err, busy
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  mem_valid, mem_wr_rd_en, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  rsp_valid, rsp_rdata, rsp_addr,
    output rsp_ready,
    input  err, busy
  );
endinterface

// File: rtl/mem_req_master.sv
// mem_req_master
// Upstream request master for a valid/ready memory. Commands are queued in a
// small FIFO and issued one at a time as single-cycle memory requests; read data
// comes back on a backpressured response port, and requests the memory never
// acknowledges are abandoned after TIMEOUT wait cycles with a pulse on err.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset
//   bus    : mem_req_master_if.master (cmd_*, mem_*, rsp_*, err, busy)
module mem_req_master #(
  parameter int MEMORY_WIDTH  = 8,
  parameter int MEMORY_DEPTH  = 16,
  parameter int ADDRESS_WIDTH = $clog2(MEMORY_DEPTH),
  parameter int FIFO_DEPTH    = 4,
  parameter int TIMEOUT       = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  mem_req_master_if.master      bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic                     wr;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [MEMORY_WIDTH-1:0]  wdata;
  } cmd_t;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  // ---------------- command FIFO ----------------
  cmd_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             full, empty, push, pop;
  cmd_t             cmd_in, head;

  assign full   = (count_reg == CNT_W'(FIFO_DEPTH));
  assign empty  = (count_reg == '0);
  assign push   = bus.cmd_valid && !full;
  assign cmd_in = '{wr: bus.cmd_wr, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
  assign head   = fifo_mem[rd_ptr_reg];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_reg] <= cmd_in;
  end

  // FIFO_DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------- request FSM ----------------
  state_t                   state_reg, state_next;
  logic                     mem_valid_reg, mem_valid_next;
  logic                     mem_wr_reg, mem_wr_next;
  logic [ADDRESS_WIDTH-1:0] mem_addr_reg, mem_addr_next;
  logic [MEMORY_WIDTH-1:0]  mem_wdata_reg, mem_wdata_next;
  logic                     rsp_valid_reg, rsp_valid_next;
  logic [MEMORY_WIDTH-1:0]  rsp_rdata_reg, rsp_rdata_next;
  logic [ADDRESS_WIDTH-1:0] rsp_addr_reg, rsp_addr_next;
  logic                     err_reg, err_next;
  logic [TMO_W-1:0]         tmo_reg, tmo_next;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      mem_valid_reg <= 1'b0;
      mem_wr_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_addr_reg  <= '0;
      err_reg       <= 1'b0;
      tmo_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      mem_valid_reg <= mem_valid_next;
      mem_wr_reg    <= mem_wr_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_addr_reg  <= rsp_addr_next;
      err_reg       <= err_next;
      tmo_reg       <= tmo_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    mem_valid_next = mem_valid_reg;
    mem_wr_next    = mem_wr_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_addr_next  = rsp_addr_reg;
    err_next       = 1'b0;
    tmo_next       = tmo_reg;
    pop            = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (!empty) begin
          pop            = 1'b1;
          mem_wr_next    = head.wr;
          mem_addr_next  = head.addr;
          mem_wdata_next = head.wdata;
          mem_valid_next = 1'b1;
          state_next     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // The memory samples the strobe at this edge; request fields stay put.
        mem_valid_next = 1'b0;
        tmo_next       = '0;
        state_next     = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mem_ready) begin
          if (mem_wr_reg) begin
            state_next = ST_IDLE;
          end else begin
            rsp_rdata_next = bus.mem_rdata;
            rsp_addr_next  = mem_addr_reg;
            rsp_valid_next = 1'b1;
            state_next     = ST_RESP;
          end
        end else begin
          tmo_next = tmo_reg + 1'b1;
          // Abort on the TIMEOUT-th silent cycle; the counter stops at TIMEOUT.
          if (tmo_reg == TMO_W'(TIMEOUT - 1)) begin
            err_next   = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.cmd_ready    = !full;
  assign bus.mem_valid    = mem_valid_reg;
  assign bus.mem_wr_rd_en = mem_wr_reg;
  assign bus.mem_addr     = mem_addr_reg;
  assign bus.mem_wdata    = mem_wdata_reg;
  assign bus.rsp_valid    = rsp_valid_reg;
  assign bus.rsp_rdata    = rsp_rdata_reg;
  assign bus.rsp_addr     = rsp_addr_reg;
  assign bus.err          = err_reg;
  assign bus.busy         = (state_reg != ST_IDLE) || !empty;
endmodule

// File: tb/tb_mem_req_master.sv
// tb_mem_req_master
// Drives directed command sequences into mem_req_master, models the memory, and
// checks memory requests and read responses against expectation queues filled
// at command acceptance.
module tb_mem_req_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_req_master_if #(.MEMORY_WIDTH(8), .ADDRESS_WIDTH(4)) bus ();

  mem_req_master #(
    .MEMORY_WIDTH(8), .MEMORY_DEPTH(16), .ADDRESS_WIDTH(4),
    .FIFO_DEPTH(4), .TIMEOUT(15)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.master)
  );

  typedef struct {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] wdata;
  } req_t;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } rsp_t;

  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];

  int checks  = 0;
  int errors  = 0;
  int mem_cnt = 0;
  int err_cnt = 0;
  logic mv_prev  = 1'b0;
  logic err_prev = 1'b0;

  // ---------------- memory model ----------------
  logic [7:0] mem_model [16];
  logic       mem_stall = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= 8'h00;
    end else begin
      bus.mem_ready <= 1'b0;
      if (bus.mem_valid && !mem_stall) begin
        if (bus.mem_wr_rd_en) mem_model[bus.mem_addr] <= bus.mem_wdata;
        else                  bus.mem_rdata <= mem_model[bus.mem_addr];
        bus.mem_ready <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (bus.mem_valid) begin
      mem_cnt++;
      checks++;
      if (mv_prev) begin
        errors++;
        $display("FAIL mem_valid_consecutive actual=1 required=0 t=%0t", $time);
      end
      if (exp_req_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL mem_req_unexpected addr=%0h t=%0t", bus.mem_addr, $time);
      end else begin
        req_t r;
        r = exp_req_q.pop_front();
        check("mem_req_wr", 32'(bus.mem_wr_rd_en), 32'(r.wr));
        check("mem_req_addr", 32'(bus.mem_addr), 32'(r.addr));
        if (r.wr) check("mem_req_wdata", 32'(bus.mem_wdata), 32'(r.wdata));
        $display("mem req wr=%0b addr=%0h wdata=%02h", bus.mem_wr_rd_en, bus.mem_addr, bus.mem_wdata);
      end
    end
    mv_prev = bus.mem_valid;

    if (bus.rsp_valid && bus.rsp_ready) begin
      if (exp_rsp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected addr=%0h data=%02h t=%0t", bus.rsp_addr, bus.rsp_rdata, $time);
      end else begin
        rsp_t e;
        e = exp_rsp_q.pop_front();
        check("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.data));
        check("rsp_addr", 32'(bus.rsp_addr), 32'(e.addr));
        $display("rsp addr=%0h data=%02h", bus.rsp_addr, bus.rsp_rdata);
      end
    end

    if (bus.err) begin
      err_cnt++;
      checks++;
      if (err_prev) begin
        errors++;
        $display("FAIL err_pulse_width actual=2+ required=1 t=%0t", $time);
      end
    end
    err_prev = bus.err;
  end

  // ---------------- stimulus helpers ----------------
  // Offers one command and returns just after the edge that accepted it.
  task automatic send_cmd(input logic wr, input logic [3:0] addr, input logic [7:0] wdata,
                          input bit want_rsp, input logic [7:0] rdata);
    int n;
    req_t r;
    rsp_t s;
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    n = 0;
    while (!bus.cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL cmd_accept_timeout addr=%0h t=%0t", addr, $time);
    end else begin
      @(posedge clk);
      r.wr = wr; r.addr = addr; r.wdata = wdata;
      exp_req_q.push_back(r);
      if (want_rsp) begin
        s.addr = addr; s.data = rdata;
        exp_rsp_q.push_back(s);
      end
      #1;
      $display("cmd wr=%0b addr=%0h wdata=%02h", wr, addr, wdata);
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((bus.busy || bus.rsp_valid) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL wait_idle_timeout busy=%0b t=%0t", bus.busy, $time);
    end
  endtask

  task automatic wait_rsp_valid(input int budget);
    int n;
    n = 0;
    while (!bus.rsp_valid && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL wait_rsp_timeout t=%0t", $time);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int snap;
    bus.cmd_valid = 1'b0;
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = 4'h0;
    bus.cmd_wdata = 8'h00;
    bus.rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: write 3 = A5, read it back, check issue and response latency
    send_cmd(1'b1, 4'd3, 8'hA5, 1'b0, 8'h00);
    check("t1_mv_n0", 32'(bus.mem_valid), 32'd0);
    @(posedge clk); #1;
    check("t1_mv_n1", 32'(bus.mem_valid), 32'd1);
    @(posedge clk); #1;
    check("t1_mv_n2", 32'(bus.mem_valid), 32'd0);
    wait_idle(50);
    send_cmd(1'b0, 4'd3, 8'h00, 1'b1, 8'hA5);
    @(posedge clk); #1;
    check("t1_rv_n1", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("t1_rv_n2", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("t1_rv_n3", 32'(bus.rsp_valid), 32'd1);
    check("t1_rdata_n3", 32'(bus.rsp_rdata), 32'hA5);
    check("t1_raddr_n3", 32'(bus.rsp_addr), 32'd3);
    wait_idle(50);

    // 2: FIFO fills while stalled in RESP; fifth command is held
    bus.rsp_ready = 1'b0;
    send_cmd(1'b0, 4'd3, 8'h00, 1'b1, 8'hA5);
    wait_rsp_valid(50);
    for (int i = 0; i < 4; i++) send_cmd(1'b1, 4'(10 + i), 8'(8'h10 + i), 1'b0, 8'h00);
    check("t2_full_ready", 32'(bus.cmd_ready), 32'd0);
    check("t2_full_busy", 32'(bus.busy), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = 1'b1;
    bus.cmd_addr  = 4'd14;
    bus.cmd_wdata = 8'h14;
    repeat (3) begin
      @(posedge clk); #1;
      check("t2_held_ready", 32'(bus.cmd_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    send_cmd(1'b1, 4'd14, 8'h14, 1'b0, 8'h00);
    wait_idle(100);

    // 3: response held stable under backpressure, queued command waits
    bus.rsp_ready = 1'b0;
    send_cmd(1'b1, 4'd7, 8'h77, 1'b0, 8'h00);
    send_cmd(1'b0, 4'd7, 8'h00, 1'b1, 8'h77);
    send_cmd(1'b1, 4'd8, 8'h88, 1'b0, 8'h00);
    wait_rsp_valid(50);
    snap = mem_cnt;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("t3_hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("t3_hold_rdata", 32'(bus.rsp_rdata), 32'h77);
      check("t3_hold_addr", 32'(bus.rsp_addr), 32'd7);
      check("t3_no_new_req", 32'(mem_cnt), 32'(snap));
    end
    bus.rsp_ready = 1'b1;
    wait_idle(100);

    // 4: memory never ready -> single err pulse after 15 wait cycles
    mem_stall = 1'b1;
    send_cmd(1'b0, 4'd9, 8'h00, 1'b0, 8'h00);
    send_cmd(1'b1, 4'd9, 8'h99, 1'b0, 8'h00);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      check("t4_err_early", 32'(bus.err), 32'd0);
    end
    @(posedge clk); #1;
    check("t4_err_pulse", 32'(bus.err), 32'd1);
    check("t4_no_rsp", 32'(bus.rsp_valid), 32'd0);
    mem_stall = 1'b0;
    @(posedge clk); #1;
    check("t4_err_end", 32'(bus.err), 32'd0);
    check("t4_next_mv", 32'(bus.mem_valid), 32'd1);
    check("t4_next_addr", 32'(bus.mem_addr), 32'd9);
    check("t4_next_wr", 32'(bus.mem_wr_rd_en), 32'd1);
    wait_idle(100);

    // 5: reset mid-WAIT with two commands queued
    mem_stall = 1'b1;
    send_cmd(1'b0, 4'd5, 8'h00, 1'b0, 8'h00);
    send_cmd(1'b1, 4'd5, 8'h55, 1'b0, 8'h00);
    send_cmd(1'b1, 4'd6, 8'h66, 1'b0, 8'h00);
    check("t5_busy_before", 32'(bus.busy), 32'd1);
    exp_req_q.delete();
    rst = 1'b1;
    #1;
    check("t5_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("t5_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("t5_mem_wr", 32'(bus.mem_wr_rd_en), 32'd0);
    check("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("t5_err", 32'(bus.err), 32'd0);
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    mem_stall = 1'b0;
    snap = mem_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("t5_no_later_req", 32'(mem_cnt), 32'(snap));
    check("t5_busy_after", 32'(bus.busy), 32'd0);

    // 6: fill all addresses, read them back in order
    bus.rsp_ready = 1'b1;
    for (int a = 0; a < 16; a++) send_cmd(1'b1, 4'(a), 8'(a) ^ 8'h5A, 1'b0, 8'h00);
    for (int a = 0; a < 16; a++) send_cmd(1'b0, 4'(a), 8'h00, 1'b1, 8'(a) ^ 8'h5A);
    wait_idle(400);

    repeat (5) @(posedge clk);
    #1;
    check("err_pulse_count", 32'(err_cnt), 32'd1);
    check("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
    check("rsp_queue_drained", 32'(exp_rsp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
